taillight_monitor: RTL and testbench

- Observer for the six tail-light lamp outputs (LA, LB, LC, RA, RB, RC) driven by the turn-signal FSM.
- Samples the lamps on the divided clock-enable strobe and decodes the active side and sweep step.
- Checks that the lamps follow the legal sweep sequence, counts completed sweeps, and latches the first protocol error.
- Sits beside the turn-signal FSM on the lab board and drives the LED/7-segment status logic.

---
 rtl/taillight_monitor_if.sv | 34 +++
 rtl/taillight_monitor.sv | 193 +++++++++++++++++++
 tb/tb_taillight_monitor.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/taillight_monitor_if.sv
// Lamp and status bundle between the turn-signal FSM side and the monitor.
// The master drives the lamps and strobes; the slave returns the status.
interface taillight_monitor_if #(
    parameter int CNT_W = 8
);
    logic             sample_en;
    logic             LA;
    logic             LB;
    logic             LC;
    logic             RA;
    logic             RB;
    logic             RC;
    logic             clr;
    logic             left_active;
    logic             right_active;
    logic             hazard;
    logic [1:0]       step;
    logic             sweep_done;
    logic [CNT_W-1:0] sweep_count;
    logic             err;
    logic [1:0]       err_code;

    modport master (
        output sample_en, LA, LB, LC, RA, RB, RC, clr,
        input  left_active, right_active, hazard, step,
        input  sweep_done, sweep_count, err, err_code
    );

    modport slave (
        input  sample_en, LA, LB, LC, RA, RB, RC, clr,
        output left_active, right_active, hazard, step,
        output sweep_done, sweep_count, err, err_code
    );
endinterface

// File: rtl/taillight_monitor.sv
// Tail-light sweep observer: decodes lamps on each strobe, tracks the
// sweep FSM, counts completed sweeps and latches the first error.
module taillight_monitor #(
    parameter int CNT_W = 8
) (
    input logic                clk,
    input logic                rst,
    taillight_monitor_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LEFT   = 2'd1;
    localparam logic [1:0] S_RIGHT  = 2'd2;
    localparam logic [1:0] S_HAZARD = 2'd3;

    localparam logic [1:0] E_NONE = 2'b00;
    localparam logic [1:0] E_ILL  = 2'b01;
    localparam logic [1:0] E_SEQ  = 2'b10;
    localparam logic [1:0] E_SIDE = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state;
    logic [1:0]       step_q;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic [1:0]       code_q;

    logic [2:0] l_raw;
    logic [2:0] r_raw;
    logic [1:0] l_step;
    logic [1:0] r_step;
    logic       l_ill;
    logic       r_ill;

    logic [1:0] nstate;
    logic [1:0] nstep;
    logic       done;
    logic [1:0] ecode;
    logic [1:0] exp_s;
    logic [1:0] v;
    logic       mism;
    logic       split;

    assign l_raw = {bus.LA, bus.LB, bus.LC};
    assign r_raw = {bus.RA, bus.RB, bus.RC};

    // Left lamps light inward-out: LC, then LB, then LA.
    always_comb begin
        l_step = 2'd0;
        l_ill  = 1'b0;
        case (l_raw)
            3'b000:  l_step = 2'd0;
            3'b001:  l_step = 2'd1;
            3'b011:  l_step = 2'd2;
            3'b111:  l_step = 2'd3;
            default: l_ill  = 1'b1;
        endcase
    end

    // Right lamps light inward-out: RA, then RB, then RC.
    always_comb begin
        r_step = 2'd0;
        r_ill  = 1'b0;
        case (r_raw)
            3'b000:  r_step = 2'd0;
            3'b100:  r_step = 2'd1;
            3'b110:  r_step = 2'd2;
            3'b111:  r_step = 2'd3;
            default: r_ill  = 1'b1;
        endcase
    end

    // Per-state view of the active side and the cross-side mismatch.
    always_comb begin
        v     = l_step;
        mism  = 1'b0;
        split = 1'b0;
        case (state)
            S_LEFT: begin
                v    = l_step;
                mism = (r_step != 2'd0);
            end
            S_RIGHT: begin
                v    = r_step;
                mism = (l_step != 2'd0);
            end
            S_HAZARD: begin
                v     = l_step;
                mism  = (l_step != 2'd0) && (r_step != 2'd0)
                        && (l_step != r_step);
                split = (l_step != r_step);
            end
            default: begin
                v     = l_step;
                mism  = 1'b0;
                split = 1'b0;
            end
        endcase
    end

    // Expected next step wraps 3 -> 0, which marks the sweep end.
    assign exp_s = step_q + 2'd1;

    // Sweep sequencing; error priority is illegal > side > sequence.
    always_comb begin
        nstate = state;
        nstep  = step_q;
        done   = 1'b0;
        ecode  = E_NONE;
        if (l_ill || r_ill) begin
            ecode  = E_ILL;
            nstate = S_IDLE;
            nstep  = 2'd0;
        end else if (state == S_IDLE) begin
            nstep = 2'd0;
            if (l_step == 2'd1 && r_step == 2'd0) begin
                nstate = S_LEFT;
                nstep  = 2'd1;
            end else if (l_step == 2'd0 && r_step == 2'd1) begin
                nstate = S_RIGHT;
                nstep  = 2'd1;
            end else if (l_step == 2'd1 && r_step == 2'd1) begin
                nstate = S_HAZARD;
                nstep  = 2'd1;
            end else if (l_step != 2'd0 || r_step != 2'd0) begin
                ecode = E_SEQ;
            end
        end else begin
            nstate = S_IDLE;
            nstep  = 2'd0;
            if (mism) begin
                ecode = E_SIDE;
            end else if (split) begin
                ecode = E_SEQ;
            end else if (v == exp_s) begin
                if (step_q == 2'd3) begin
                    done = 1'b1;
                end else begin
                    nstate = state;
                    nstep  = v;
                end
            end else if (v != 2'd0) begin
                ecode = E_SEQ;
            end
        end
    end

    // FSM, step and completion pulse advance only on the strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            step_q <= 2'd0;
            done_q <= 1'b0;
        end else if (bus.sample_en) begin
            state  <= nstate;
            step_q <= nstep;
            done_q <= done;
        end else begin
            done_q <= 1'b0;
        end
    end

    // Sticky first error and saturating sweep count; clr overrides both.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q  <= 1'b0;
            code_q <= E_NONE;
            cnt_q  <= '0;
        end else if (bus.clr) begin
            err_q  <= 1'b0;
            code_q <= E_NONE;
            cnt_q  <= '0;
        end else if (bus.sample_en) begin
            if (ecode != E_NONE && !err_q) begin
                err_q  <= 1'b1;
                code_q <= ecode;
            end
            if (done && cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.left_active  = (state == S_LEFT) || (state == S_HAZARD);
    assign bus.right_active = (state == S_RIGHT) || (state == S_HAZARD);
    assign bus.hazard       = (state == S_HAZARD);
    assign bus.step         = step_q;
    assign bus.sweep_done   = done_q;
    assign bus.sweep_count  = cnt_q;
    assign bus.err          = err_q;
    assign bus.err_code     = code_q;
endmodule

// File: tb/tb_taillight_monitor.sv
// Directed bench for taillight_monitor: sweeps, hazard saturation,
// abort, error priority, gating, async reset and clr overlap.
module tb_taillight_monitor;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    taillight_monitor_if #(.CNT_W(8)) bus ();
    taillight_monitor_if #(.CNT_W(2)) sbus ();

    taillight_monitor #(.CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    taillight_monitor #(.CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (sbus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] l, input logic [2:0] r,
                         input logic se, input logic c);
        {bus.LA, bus.LB, bus.LC}   = l;
        {bus.RA, bus.RB, bus.RC}   = r;
        {sbus.LA, sbus.LB, sbus.LC} = l;
        {sbus.RA, sbus.RB, sbus.RC} = r;
        bus.sample_en  = se;
        sbus.sample_en = se;
        bus.clr        = c;
        sbus.clr       = c;
    endtask

    task automatic strobe(input logic [2:0] l, input logic [2:0] r,
                          input logic c);
        drive(l, r, 1'b1, c);
        tick();
        bus.sample_en  = 1'b0;
        sbus.sample_en = 1'b0;
        bus.clr        = 1'b0;
        sbus.clr       = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.clr  = 1'b1;
        sbus.clr = 1'b1;
        tick();
        bus.clr  = 1'b0;
        sbus.clr = 1'b0;
    endtask

    function automatic logic [2:0] lp(input int k);
        case (k)
            1:       return 3'b001;
            2:       return 3'b011;
            3:       return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] rp(input int k);
        case (k)
            1:       return 3'b100;
            2:       return 3'b110;
            3:       return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b0;
        drive(3'b000, 3'b000, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_act", {29'd0, bus.left_active, bus.right_active,
                        bus.hazard}, 32'd0);
        chk("rst_step", {30'd0, bus.step}, 32'd0);
        chk("rst_cnt", {24'd0, bus.sweep_count}, 32'd0);
        chk("rst_err", {28'd0, bus.sweep_done, bus.err, bus.err_code},
            32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // plain left sweep
        for (int k = 1; k <= 3; k++) begin
            strobe(lp(k), 3'b000, 1'b0);
            chk("l_active", {31'd0, bus.left_active}, 32'd1);
            chk("l_step", {30'd0, bus.step}, k);
        end
        strobe(3'b000, 3'b000, 1'b0);
        chk("l_done", {31'd0, bus.sweep_done}, 32'd1);
        chk("l_cnt", {24'd0, bus.sweep_count}, 32'd1);
        chk("l_err", {31'd0, bus.err}, 32'd0);
        chk("l_idle", {31'd0, bus.left_active}, 32'd0);
        tick();
        chk("l_pulse", {31'd0, bus.sweep_done}, 32'd0);

        // gating, then async reset mid-sweep at step 2
        strobe(3'b001, 3'b000, 1'b0);
        drive(3'b111, 3'b111, 1'b0, 1'b0);
        tick();
        drive(3'b010, 3'b000, 1'b0, 1'b0);
        tick();
        chk("gate_step", {30'd0, bus.step}, 32'd1);
        chk("gate_err", {31'd0, bus.err}, 32'd0);
        strobe(3'b011, 3'b000, 1'b0);
        chk("gate_step2", {30'd0, bus.step}, 32'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_step", {30'd0, bus.step}, 32'd0);
        chk("arst_act", {31'd0, bus.left_active}, 32'd0);
        chk("arst_cnt", {24'd0, bus.sweep_count}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // hazard sweeps; narrow counter saturates at 3
        for (int s = 0; s < 5; s++) begin
            for (int k = 1; k <= 3; k++) begin
                strobe(lp(k), rp(k), 1'b0);
                chk("hz_flag", {31'd0, bus.hazard}, 32'd1);
                chk("hz_step", {30'd0, bus.step}, k);
            end
            strobe(3'b000, 3'b000, 1'b0);
            chk("hz_done", {31'd0, bus.sweep_done}, 32'd1);
            if (s == 2)
                chk("hz_cnt3", {24'd0, bus.sweep_count}, 32'd3);
        end
        chk("hz_cnt5", {24'd0, bus.sweep_count}, 32'd5);
        chk("sat_cnt", {30'd0, sbus.sweep_count}, 32'd3);
        chk("hz_err", {31'd0, bus.err}, 32'd0);

        // abort is silent, illegal pattern latches 01
        strobe(3'b001, 3'b000, 1'b0);
        strobe(3'b011, 3'b000, 1'b0);
        strobe(3'b000, 3'b000, 1'b0);
        chk("ab_done", {31'd0, bus.sweep_done}, 32'd0);
        chk("ab_idle", {31'd0, bus.left_active}, 32'd0);
        chk("ab_err", {31'd0, bus.err}, 32'd0);
        chk("ab_cnt", {24'd0, bus.sweep_count}, 32'd5);
        strobe(3'b010, 3'b000, 1'b0);
        chk("ill_err", {31'd0, bus.err}, 32'd1);
        chk("ill_code", {30'd0, bus.err_code}, 32'd1);

        // clr alone, then skipped step
        pulse_clr();
        chk("clr_err", {28'd0, 1'b0, bus.err, bus.err_code}, 32'd0);
        chk("clr_cnt", {24'd0, bus.sweep_count}, 32'd0);
        strobe(3'b001, 3'b000, 1'b0);
        strobe(3'b111, 3'b000, 1'b0);
        chk("seq_code", {30'd0, bus.err_code}, 32'd2);
        chk("seq_idle", {31'd0, bus.left_active}, 32'd0);

        // side mismatch
        pulse_clr();
        strobe(3'b001, 3'b000, 1'b0);
        strobe(3'b011, 3'b100, 1'b0);
        chk("side_code", {30'd0, bus.err_code}, 32'd3);
        chk("side_idle", {30'd0, bus.step}, 32'd0);

        // illegal beats sequence; first error sticks
        pulse_clr();
        strobe(3'b010, 3'b110, 1'b0);
        chk("pri_code", {30'd0, bus.err_code}, 32'd1);
        strobe(3'b111, 3'b000, 1'b0);
        chk("stk_code", {30'd0, bus.err_code}, 32'd1);
        chk("stk_err", {31'd0, bus.err}, 32'd1);

        // right sweep, then clr on the completing sample
        pulse_clr();
        for (int k = 1; k <= 3; k++) begin
            strobe(3'b000, rp(k), 1'b0);
            chk("r_active", {31'd0, bus.right_active}, 32'd1);
        end
        strobe(3'b000, 3'b000, 1'b0);
        chk("r_cnt", {24'd0, bus.sweep_count}, 32'd1);
        for (int k = 1; k <= 3; k++)
            strobe(lp(k), 3'b000, 1'b0);
        strobe(3'b000, 3'b000, 1'b1);
        chk("cd_done", {31'd0, bus.sweep_done}, 32'd1);
        chk("cd_cnt", {24'd0, bus.sweep_count}, 32'd0);
        chk("cd_err", {31'd0, bus.err}, 32'd0);
        chk("cd_idle", {31'd0, bus.left_active}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
